cache_line_replace: RTL and testbench

Line replacement engine for the cache. On a miss it takes ownership of the cache data RAM (asserts `sel` toward the data RAM mux) and writes the victim line back to main memory word by word if it is dirty. It then refills the line from memory into the selected way and pulses `done` to the read/write module. It drives the `ri_*` side of the data RAM port and an Avalon-MM-style single-word master toward memory.

---
 rtl/cache_line_replace.sv | 164 ++++++++++++++++
 tb/tb_cache_line_replace.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_replace.sv
// Cache line replacement engine: writes back a dirty victim line word by word,
// then refills the line from memory into the selected way of the data RAM.
module cache_line_replace #(
   parameter int ADDR_WIDTH   = 8,
   parameter int OFFSET_WIDTH = 3
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req,
   input  logic                               req_writeBack,
   input  logic [31:0]                        req_wbAddress,
   input  logic [31:0]                        req_fillAddress,
   input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] req_index,
   input  logic [1:0]                         req_channel,
   output logic                               busy,
   output logic                               done,
   output logic                               sel,
   output logic [ADDR_WIDTH-1:0]              ri_readAddress,
   output logic [1:0]                         ri_rwChannel,
   input  logic [31:0]                        ri_readData,
   output logic [ADDR_WIDTH-1:0]              ri_writeAddress,
   output logic [3:0]                         ri_writeByteEnable,
   output logic                               ri_writeEnable,
   output logic [31:0]                        ri_writeData,
   output logic [31:0]                        mem_address,
   output logic                               mem_read,
   output logic                               mem_write,
   output logic [31:0]                        mem_writeData,
   output logic [3:0]                         mem_byteEnable,
   input  logic [31:0]                        mem_readData,
   input  logic                               mem_waitRequest,
   input  logic                               mem_readDataValid
);

   localparam int INDEX_W = ADDR_WIDTH - OFFSET_WIDTH;
   localparam int TAG_W   = 30 - OFFSET_WIDTH;
   localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;
   localparam logic [OFFSET_WIDTH-1:0] ZERO_OFS  = '0;

   typedef enum logic [2:0] {
      IDLE,
      WB_RD,
      WB_WR,
      FILL_RD,
      FILL_WAIT,
      DONE_ST
   } stateT;

   stateT                   state;
   logic [OFFSET_WIDTH-1:0] cnt;
   logic [OFFSET_WIDTH-1:0] cntNext;
   logic [INDEX_W-1:0]      index;
   logic [TAG_W-1:0]        wbTag;
   logic [TAG_W-1:0]        fillTag;
   logic                    fillWrite;
   logic                    unusedAddrBits;

   assign cntNext        = cnt + 1'b1;
   assign unusedAddrBits = ^{req_wbAddress[OFFSET_WIDTH+1:0], req_fillAddress[OFFSET_WIDTH+1:0]};

   // Refill data goes straight from the memory bus into the RAM in the valid cycle.
   assign fillWrite          = (state == FILL_WAIT) && mem_readDataValid;
   assign ri_writeEnable     = fillWrite;
   assign ri_writeAddress    = fillWrite ? {index, cnt} : '0;
   assign ri_writeData       = fillWrite ? mem_readData : '0;
   assign ri_writeByteEnable = fillWrite ? 4'hF : 4'h0;
   // The read address is held through WB_WR, so RAM data stays stable across stalls.
   assign mem_writeData      = (state == WB_WR) ? ri_readData : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         index          <= '0;
         wbTag          <= '0;
         fillTag        <= '0;
         busy           <= 1'b0;
         sel            <= 1'b0;
         done           <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_byteEnable <= 4'h0;
         ri_readAddress <= '0;
         ri_rwChannel   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  index          <= req_index;
                  ri_rwChannel   <= req_channel;
                  wbTag          <= req_wbAddress[31:OFFSET_WIDTH+2];
                  fillTag        <= req_fillAddress[31:OFFSET_WIDTH+2];
                  cnt            <= '0;
                  busy           <= 1'b1;
                  sel            <= 1'b1;
                  mem_byteEnable <= 4'hF;
                  if (req_writeBack) begin
                     state          <= WB_RD;
                     ri_readAddress <= {req_index, ZERO_OFS};
                  end else begin
                     state       <= FILL_RD;
                     mem_read    <= 1'b1;
                     mem_address <= {req_fillAddress[31:OFFSET_WIDTH+2], ZERO_OFS, 2'b00};
                  end
               end
            end
            WB_RD: begin
               state       <= WB_WR;
               mem_write   <= 1'b1;
               mem_address <= {wbTag, cnt, 2'b00};
            end
            WB_WR: begin
               if (!mem_waitRequest) begin
                  mem_write <= 1'b0;
                  if (cnt == LAST_WORD) begin
                     cnt         <= '0;
                     state       <= FILL_RD;
                     mem_read    <= 1'b1;
                     mem_address <= {fillTag, ZERO_OFS, 2'b00};
                  end else begin
                     cnt            <= cntNext;
                     state          <= WB_RD;
                     ri_readAddress <= {index, cntNext};
                  end
               end
            end
            FILL_RD: begin
               if (!mem_waitRequest) begin
                  mem_read <= 1'b0;
                  state    <= FILL_WAIT;
               end
            end
            FILL_WAIT: begin
               if (mem_readDataValid) begin
                  if (cnt == LAST_WORD) begin
                     cnt   <= '0;
                     state <= DONE_ST;
                     done  <= 1'b1;
                  end else begin
                     cnt         <= cntNext;
                     state       <= FILL_RD;
                     mem_read    <= 1'b1;
                     mem_address <= {fillTag, cntNext, 2'b00};
                  end
               end
            end
            DONE_ST: begin
               state          <= IDLE;
               busy           <= 1'b0;
               sel            <= 1'b0;
               cnt            <= '0;
               mem_address    <= '0;
               mem_byteEnable <= 4'h0;
               ri_readAddress <= '0;
               ri_rwChannel   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_line_replace.sv
// Directed bench for cache_line_replace with behavioural data RAM and memory models.
module tb_cache_line_replace;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        req_writeBack;
   logic [31:0] req_wbAddress;
   logic [31:0] req_fillAddress;
   logic [4:0]  req_index;
   logic [1:0]  req_channel;
   logic        busy;
   logic        done;
   logic        sel;
   logic [7:0]  ri_readAddress;
   logic [1:0]  ri_rwChannel;
   logic [31:0] ri_readData;
   logic [7:0]  ri_writeAddress;
   logic [3:0]  ri_writeByteEnable;
   logic        ri_writeEnable;
   logic [31:0] ri_writeData;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writeData;
   logic [3:0]  mem_byteEnable;
   logic [31:0] mem_readData;
   logic        mem_waitRequest;
   logic        mem_readDataValid;

   cache_line_replace #(.ADDR_WIDTH(8), .OFFSET_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_writeBack(req_writeBack),
      .req_wbAddress(req_wbAddress), .req_fillAddress(req_fillAddress),
      .req_index(req_index), .req_channel(req_channel),
      .busy(busy), .done(done), .sel(sel),
      .ri_readAddress(ri_readAddress), .ri_rwChannel(ri_rwChannel), .ri_readData(ri_readData),
      .ri_writeAddress(ri_writeAddress), .ri_writeByteEnable(ri_writeByteEnable),
      .ri_writeEnable(ri_writeEnable), .ri_writeData(ri_writeData),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writeData(mem_writeData), .mem_byteEnable(mem_byteEnable),
      .mem_readData(mem_readData), .mem_waitRequest(mem_waitRequest),
      .mem_readDataValid(mem_readDataValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Data RAM: one-cycle read latency, write on the clock edge.
   logic [31:0] ram [0:3][0:255];
   logic        preloadEn   = 1'b0;
   logic [1:0]  preloadCh   = '0;
   logic [7:0]  preloadAddr = '0;
   logic [31:0] preloadData = '0;
   int          ramWrites   = 0;
   int          badBe       = 0;

   always @(posedge clk) begin
      ri_readData <= ram[ri_rwChannel][ri_readAddress];
      if (preloadEn) begin
         ram[preloadCh][preloadAddr] <= preloadData;
      end else if (ri_writeEnable) begin
         ram[ri_rwChannel][ri_writeAddress] <= ri_writeData;
         ramWrites <= ramWrites + 1;
         if (ri_writeByteEnable != 4'hF) badBe <= badBe + 1;
      end
   end

   // Memory slave: read data returns one cycle after acceptance, optional stall and spurious valid.
   logic [31:0] readLog   [0:255];
   logic [31:0] wrAddrLog [0:255];
   logic [31:0] wrDataLog [0:255];
   int          readCount   = 0;
   int          writeCount  = 0;
   int          stallRead   = -1;
   int          stallWrite  = -1;
   int          stallLen    = 0;
   int          stallArm    = 0;
   int          spurReadIdx = -1;
   int          lastArm     = 0;
   int          stallCnt    = 0;
   logic        rdPending   = 1'b0;
   logic [31:0] rdData      = '0;
   logic [31:0] stallAddr   = '0;
   logic [31:0] stallWd     = '0;
   logic [1:0]  stallStb    = '0;
   logic        hit;
   int          doneCount   = 0;

   initial begin
      mem_waitRequest   = 1'b0;
      mem_readDataValid = 1'b0;
      mem_readData      = '0;
   end

   always @(negedge clk) begin
      if (done === 1'b1) doneCount++;
      if (!rst_n) begin
         rdPending         = 1'b0;
         mem_readDataValid = 1'b0;
         mem_readData      = '0;
         mem_waitRequest   = 1'b0;
      end else begin
         if (rdPending) begin
            mem_readDataValid = 1'b1;
            mem_readData      = rdData;
            rdPending         = 1'b0;
         end else if (mem_read && readCount == spurReadIdx) begin
            mem_readDataValid = 1'b1;
            mem_readData      = 32'hBAD0_BAD0;
         end else begin
            mem_readDataValid = 1'b0;
            mem_readData      = '0;
         end
         if (stallArm != lastArm) begin
            stallCnt = 0;
            lastArm  = stallArm;
         end
         hit = (mem_read && readCount == stallRead) || (mem_write && writeCount == stallWrite);
         if (hit && stallCnt > 0) begin
            checkVal("stallAddr", mem_address, stallAddr);
            checkVal("stallStrobe", {30'd0, mem_read, mem_write}, {30'd0, stallStb});
            checkVal("stallWrData", mem_writeData, stallWd);
         end
         if (hit && stallCnt < stallLen) begin
            if (stallCnt == 0) begin
               stallAddr = mem_address;
               stallWd   = mem_writeData;
               stallStb  = {mem_read, mem_write};
            end
            mem_waitRequest = 1'b1;
            stallCnt++;
         end else begin
            mem_waitRequest = 1'b0;
            if (mem_read) begin
               readLog[readCount] = mem_address;
               rdData             = 32'hC000_0000 | mem_address;
               rdPending          = 1'b1;
               readCount++;
            end
            if (mem_write) begin
               wrAddrLog[writeCount] = mem_address;
               wrDataLog[writeCount] = mem_writeData;
               writeCount++;
            end
         end
      end
   end

   task automatic preloadLine(input logic [1:0] ch, input int idx, input logic [31:0] base);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         preloadEn   = 1'b1;
         preloadCh   = ch;
         preloadAddr = 8'(idx * 8 + i);
         preloadData = base + 32'(i);
      end
      @(negedge clk);
      preloadEn = 1'b0;
   endtask

   // Issues one request and returns the cycle (relative to the req edge) in which done is seen.
   task automatic runReq(input logic wb, input logic [31:0] wbA, input logic [31:0] fillA,
                         input logic [4:0] idx, input logic [1:0] ch, input int pulseAt,
                         output int lat);
      logic found;
      @(negedge clk);
      req             = 1'b1;
      req_writeBack   = wb;
      req_wbAddress   = wbA;
      req_fillAddress = fillA;
      req_index       = idx;
      req_channel     = ch;
      @(negedge clk);
      req = 1'b0;
      checkVal("startBusySel", {30'd0, busy, sel}, 32'd3);
      checkVal("startChannel", {30'd0, ri_rwChannel}, {30'd0, ch});
      checkVal("startByteEn", {28'd0, mem_byteEnable}, 32'hF);
      found = 1'b0;
      lat   = 0;
      for (int i = 1; i <= 300 && !found; i++) begin
         if (i > 1) @(negedge clk);
         req = (i == pulseAt);
         if (done) begin
            lat   = i;
            found = 1'b1;
         end
      end
      req = 1'b0;
      if (!found) checkVal("doneTimeout", 32'd0, 32'd1);
      @(negedge clk);
      checkVal("idleAfterDone", {30'd0, busy, sel}, 32'd0);
   endtask

   task automatic checkLine(input logic [1:0] ch, input int idx, input logic [31:0] fillA);
      for (int i = 0; i < 8; i++)
         checkVal("ramWord", ram[ch][idx * 8 + i], 32'hC000_0000 | (fillA + 32'(4 * i)));
   endtask

   int lat;
   int rb;
   int wb0;
   int rw0;
   int dc0;
   logic seen;

   initial begin
      rst_n           = 1'b0;
      req             = 1'b0;
      req_writeBack   = 1'b0;
      req_wbAddress   = '0;
      req_fillAddress = '0;
      req_index       = '0;
      req_channel     = '0;
      repeat (3) @(negedge clk);
      checkVal("rstCtrl", {26'd0, busy, done, sel, mem_read, mem_write, ri_writeEnable}, 32'd0);
      checkVal("rstMemAddr", mem_address, 32'd0);
      checkVal("rstByteEn", {28'd0, mem_byteEnable}, 32'd0);
      checkVal("rstRamAddr", {14'd0, ri_rwChannel, ri_readAddress, ri_writeAddress}, 32'd0);
      rst_n = 1'b1;

      // Clean fill
      rb = readCount; rw0 = ramWrites; dc0 = doneCount;
      runReq(1'b0, 32'h0, 32'h0000_1040, 5'd5, 2'd2, 0, lat);
      checkVal("cleanLatency", lat, 32'd17);
      for (int i = 0; i < 8; i++)
         checkVal("cleanReadAddr", readLog[rb + i], 32'h0000_1040 + 32'(4 * i));
      checkVal("cleanReadCount", readCount - rb, 32'd8);
      checkVal("cleanRamWrites", ramWrites - rw0, 32'd8);
      checkLine(2'd2, 5, 32'h0000_1040);
      checkVal("cleanDoneCount", doneCount - dc0, 32'd1);

      // Dirty eviction
      preloadLine(2'd1, 5, 32'h0000_00A0);
      wb0 = writeCount;
      runReq(1'b1, 32'h0000_2040, 32'h0000_3040, 5'd5, 2'd1, 0, lat);
      checkVal("dirtyLatency", lat, 32'd33);
      checkVal("dirtyWriteCount", writeCount - wb0, 32'd8);
      for (int i = 0; i < 8; i++) begin
         checkVal("dirtyWrAddr", wrAddrLog[wb0 + i], 32'h0000_2040 + 32'(4 * i));
         checkVal("dirtyWrData", wrDataLog[wb0 + i], 32'h0000_00A0 + 32'(i));
      end
      checkLine(2'd1, 5, 32'h0000_3040);

      // Three-cycle stall on the fourth fill read
      stallRead = readCount + 3; stallLen = 3; stallArm++;
      runReq(1'b0, 32'h0, 32'h0000_1100, 5'd2, 2'd0, 0, lat);
      checkVal("fillStallLatency", lat, 32'd20);
      checkLine(2'd0, 2, 32'h0000_1100);
      stallRead = -1;

      // Two-cycle stall on the third write-back word
      preloadLine(2'd3, 3, 32'h0000_00B0);
      wb0 = writeCount;
      stallWrite = writeCount + 2; stallLen = 2; stallArm++;
      runReq(1'b1, 32'h0000_5000, 32'h0000_6000, 5'd3, 2'd3, 0, lat);
      checkVal("wbStallLatency", lat, 32'd35);
      for (int i = 0; i < 8; i++)
         checkVal("wbStallData", wrDataLog[wb0 + i], 32'h0000_00B0 + 32'(i));
      checkLine(2'd3, 3, 32'h0000_6000);
      stallWrite = -1;

      // req pulsed while busy, spurious readDataValid during FILL_RD
      dc0 = doneCount; rw0 = ramWrites;
      spurReadIdx = readCount + 2;
      runReq(1'b0, 32'h0, 32'h0000_7000, 5'd7, 2'd2, 6, lat);
      checkVal("busyReqLatency", lat, 32'd17);
      repeat (6) @(negedge clk);
      checkVal("busyReqIgnored", {31'd0, busy}, 32'd0);
      checkVal("busyReqDoneCount", doneCount - dc0, 32'd1);
      checkVal("spurRamWrites", ramWrites - rw0, 32'd8);
      checkLine(2'd2, 7, 32'h0000_7000);
      spurReadIdx = -1;

      // Reset during the fifth fill word, then a clean retry
      dc0 = doneCount; rb = readCount;
      @(negedge clk);
      req = 1'b1; req_writeBack = 1'b0; req_fillAddress = 32'h0000_4000;
      req_index = 5'd6; req_channel = 2'd0;
      @(negedge clk);
      req  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1;
         if (readCount >= rb + 5) seen = 1'b1;
         else @(negedge clk);
      end
      checkVal("rstReachedWord5", {31'd0, seen}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      checkVal("rstMidFill", {28'd0, busy, sel, mem_read, done}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkVal("rstNoDone", doneCount - dc0, 32'd0);
      runReq(1'b0, 32'h0, 32'h0000_4000, 5'd6, 2'd0, 0, lat);
      checkVal("retryLatency", lat, 32'd17);
      checkLine(2'd0, 6, 32'h0000_4000);
      checkVal("ramByteEnables", badBe, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
